// File: rtl/nx_ram_port_ctrl.sv
// nx_ram_port_ctrl: initiator-side front end for one nx_ram port.
// Requests pass straight through to the RAM. Read data is captured one cycle
// after the read into a small response FIFO. A credit scheme (queued entries
// plus the read in flight) keeps the FIFO from ever overflowing, so the
// response channel can stall freely without losing data.
module nx_ram_port_ctrl #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 36,
  parameter int RSP_DEPTH     = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_wr_data_i,
  input  logic                     req_wr_en_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  output logic [DATA_WIDTH-1:0]    rsp_data_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]    ram_wr_data_o,
  output logic                     ram_wr_en_o,
  output logic                     ram_en_o,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data_i,
  output logic                     idle_o
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int OCC_W = $clog2(RSP_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RSP_DEPTH);
  localparam logic [OCC_W:0]   CREDITS  = (OCC_W + 1)'(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [OCC_W:0]        used;
  logic                  rd_accept;
  logic                  push;
  logic                  pop;

  // Credits count every read that has been accepted but not yet popped;
  // ready depends only on registers (and reset), never on the channel inputs.
  assign used        = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
  assign req_ready_o = ~rst_i & (used < CREDITS);

  assign ram_en_o      = req_valid_i & req_ready_o;
  assign ram_wr_en_o   = ram_en_o & req_wr_en_i;
  assign ram_addr_o    = req_addr_i;
  assign ram_wr_data_o = req_wr_data_i;

  assign rd_accept   = ram_en_o & ~req_wr_en_i;
  // RAM read data is valid exactly while the in-flight flag is set.
  assign push        = inflight_q;
  assign rsp_valid_o = (occ_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_data_o  = rsp_valid_o ? fifo_q[rd_ptr_q] : '0;
  assign idle_o      = ~inflight_q & (occ_q == '0);

  // Next-state for pointers (wrapping at any depth), occupancy and in-flight flag.
  always_comb begin
    inflight_d = rd_accept;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  // Control state; reset discards the read in flight and all queued entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible through occupancy.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= ram_rd_data_i;
  end

  // Credits guarantee a free slot for every capture.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (occ_q == OCC_FULL)));

endmodule

// File: tb/tb_nx_ram_port_ctrl.sv
// Bench for nx_ram_port_ctrl: a depth-3 instance checked cycle by cycle
// against a queue model, plus a depth-1 instance for the single-credit case.
module tb_nx_ram_port_ctrl;
  localparam int AW = 10;
  localparam int DW = 36;
  localparam int D0 = 3;
  localparam int VW = DW + 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] req_addr;  logic [DW-1:0] req_wr_data;
  logic req_wr_en, req_valid, req_ready;
  logic [DW-1:0] rsp_data;  logic rsp_valid, rsp_ready;
  logic [AW-1:0] ram_addr;  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic ram_wr_en, ram_en, idle;

  logic [AW-1:0] req_addr1; logic [DW-1:0] req_wr_data1;
  logic req_wr_en1, req_valid1, req_ready1;
  logic [DW-1:0] rsp_data1; logic rsp_valid1, rsp_ready1;
  logic [AW-1:0] ram_addr1; logic [DW-1:0] ram_wr_data1, ram_rd_data1;
  logic ram_wr_en1, ram_en1, idle1;

  nx_ram_port_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(D0)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_addr_i(req_addr), .req_wr_data_i(req_wr_data), .req_wr_en_i(req_wr_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .ram_addr_o(ram_addr), .ram_wr_data_o(ram_wr_data), .ram_wr_en_o(ram_wr_en),
    .ram_en_o(ram_en), .ram_rd_data_i(ram_rd_data), .idle_o(idle));

  nx_ram_port_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_addr_i(req_addr1), .req_wr_data_i(req_wr_data1), .req_wr_en_i(req_wr_en1),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .rsp_data_o(rsp_data1), .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
    .ram_addr_o(ram_addr1), .ram_wr_data_o(ram_wr_data1), .ram_wr_en_o(ram_wr_en1),
    .ram_en_o(ram_en1), .ram_rd_data_i(ram_rd_data1), .idle_o(idle1));

  // Behavioural single-cycle registered RAM ports
  logic [DW-1:0] ram0 [0:(1<<AW)-1];
  logic [DW-1:0] ram1 [0:(1<<AW)-1];
  always @(posedge clk) if (ram_en) begin
    if (ram_wr_en) ram0[ram_addr] <= ram_wr_data; else ram_rd_data <= ram0[ram_addr];
  end
  always @(posedge clk) if (ram_en1) begin
    if (ram_wr_en1) ram1[ram_addr1] <= ram_wr_data1; else ram_rd_data1 <= ram1[ram_addr1];
  end

  // Reference model: expected responses with the cycle they become visible
  typedef struct packed { logic [DW-1:0] data; int vis; } rsp_t;
  rsp_t expq[$];
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  logic [DW-1:0] m1 [0:7];
  int cyc = 0;
  int pass_cnt = 0;
  int chk_cnt = 0;
  logic [VW-1:0] obs, exv;

  // One cycle on the depth-3 instance: drive, sample at negedge, then advance the model.
  task automatic drive_cycle(input logic v, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic rr,
                             output logic [VW-1:0] o, output logic [VW-1:0] e);
    logic e_rdy, e_val;
    logic [DW-1:0] e_dat, o_dat;
    req_valid = v; req_wr_en = we; req_addr = a; req_wr_data = d; rsp_ready = rr;
    @(negedge clk);
    e_rdy = (expq.size() < D0);
    e_val = (expq.size() != 0) && (expq[0].vis <= cyc);
    e_dat = e_val ? expq[0].data : '0;
    o_dat = rsp_valid ? rsp_data : '0;
    e = {e_rdy, e_val, (expq.size() == 0), v & e_rdy, v & e_rdy & we, e_dat};
    o = {req_ready, rsp_valid, idle, ram_en, ram_wr_en, o_dat};
    if (e_val && rr) void'(expq.pop_front());
    if (v && e_rdy) begin
      if (we) mdl_mem[a] = d;
      else expq.push_back('{data: mdl_mem[a], vis: cyc + 2});
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic rr);
    req_valid1 = v; req_wr_en1 = we; req_addr1 = a; req_wr_data1 = d; rsp_ready1 = rr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [DW+5:0] o, e;
    rst = 1'b1;
    req_valid = 1'b1; req_wr_en = 1'b0; req_addr = '0; req_wr_data = '0; rsp_ready = 1'b1;
    req_valid1 = 1'b1; req_wr_en1 = 1'b0; req_addr1 = '0; req_wr_data1 = '0; rsp_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = {req_ready, rsp_valid, idle, rsp_data, req_ready1, rsp_valid1, idle1};
    e = {1'b0, 1'b0, 1'b1, {DW{1'b0}}, 1'b0, 1'b0, 1'b1};
    chk_cnt++;
    if (o !== e) $display("FAIL reset_state got=%h want=%h", o, e); else pass_cnt++;
    req_valid = 1'b0; req_valid1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(0, 0, '0, '0, 1, obs, exv);
      chk_cnt++;
      if (obs !== exv) $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, obs, exv); else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    int lat = 0;
    logic [DW-1:0] got = '0;
    drive_cycle(1, 1, 10'd5, 36'h123456789, 1, obs, exv);
    chk_cnt++;
    if (obs !== exv) $display("FAIL wr_rd_write got=%h want=%h", obs, exv); else pass_cnt++;
    drive_cycle(1, 0, 10'd5, '0, 1, obs, exv);
    chk_cnt++;
    if (obs !== exv) $display("FAIL wr_rd_read got=%h want=%h", obs, exv); else pass_cnt++;
    for (int j = 1; j <= 5; j++) begin
      drive_cycle(0, 0, '0, '0, 1, obs, exv);
      chk_cnt++;
      if (obs !== exv) $display("FAIL wr_rd_cycle j=%0d got=%h want=%h", j, obs, exv); else pass_cnt++;
      if (obs[DW+3] && lat == 0) begin lat = j; got = obs[DW-1:0]; end
    end
    chk_cnt++;
    if (lat != 2 || got !== 36'h123456789)
      $display("FAIL wr_rd_latency lat=%0d data=%h want lat=2 data=123456789", lat, got);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    int n = 0;
    int first = -1;
    int last = -1;
    for (int a = 0; a < 8; a++) begin
      drive_cycle(1, 1, AW'(a), DW'(32'h100 + a), 1, obs, exv);
      chk_cnt++;
      if (obs !== exv) $display("FAIL stream_load a=%0d got=%h want=%h", a, obs, exv); else pass_cnt++;
    end
    for (int k = 0; k < 14; k++) begin
      if (k < 8) drive_cycle(1, 0, AW'(k), '0, 1, obs, exv);
      else       drive_cycle(0, 0, '0, '0, 1, obs, exv);
      chk_cnt++;
      if (obs !== exv) $display("FAIL stream_cycle k=%0d got=%h want=%h", k, obs, exv); else pass_cnt++;
      if (k < 8) begin
        chk_cnt++;
        if (obs[DW+4] !== 1'b1) $display("FAIL stream_ready k=%0d got=%b want=1", k, obs[DW+4]); else pass_cnt++;
      end
      if (obs[DW+3]) begin
        chk_cnt++;
        if (obs[DW-1:0] !== DW'(32'h100 + n))
          $display("FAIL stream_data n=%0d got=%h want=%h", n, obs[DW-1:0], 32'h100 + n);
        else pass_cnt++;
        if (first < 0) first = k;
        last = k;
        n++;
      end
    end
    chk_cnt++;
    if (n != 8 || last - first != 7)
      $display("FAIL stream_count got n=%0d span=%0d want n=8 span=7", n, last - first);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int n = 0;
    logic [6:0] rdy_hist;
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1, 0, AW'(acc), '0, 0, obs, exv);
      chk_cnt++;
      if (obs !== exv) $display("FAIL bp_fill k=%0d got=%h want=%h", k, obs, exv); else pass_cnt++;
      if (obs[DW+4]) acc++;
    end
    chk_cnt++;
    if (acc != 3) $display("FAIL bp_accepted got=%0d want=3", acc); else pass_cnt++;
    for (int k = 0; k < 7; k++) begin
      drive_cycle(0, 0, '0, '0, 1, obs, exv);
      rdy_hist[k] = obs[DW+4];
      chk_cnt++;
      if (obs !== exv) $display("FAIL bp_drain k=%0d got=%h want=%h", k, obs, exv); else pass_cnt++;
      if (obs[DW+3]) begin
        chk_cnt++;
        if (obs[DW-1:0] !== DW'(32'h100 + n))
          $display("FAIL bp_data n=%0d got=%h want=%h", n, obs[DW-1:0], 32'h100 + n);
        else pass_cnt++;
        n++;
      end
    end
    chk_cnt++;
    if (n != 3 || rdy_hist[1:0] !== 2'b10)
      $display("FAIL bp_release got n=%0d ready[1:0]=%b want n=3 ready[1:0]=10", n, rdy_hist[1:0]);
    else pass_cnt++;
  endtask

  task automatic test_mixed();
    logic [DW-1:0] got [$];
    int wr_cnt = 0;
    logic [3:0] we_seq = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive_cycle(1, we_seq[k], 10'd2, (k == 0) ? 36'hA : 36'hB, 1, obs, exv);
      else       drive_cycle(0, 0, '0, '0, 1, obs, exv);
      chk_cnt++;
      if (obs !== exv) $display("FAIL mixed_cycle k=%0d got=%h want=%h", k, obs, exv); else pass_cnt++;
      if (obs[DW]) wr_cnt++;
      if (obs[DW+3]) got.push_back(obs[DW-1:0]);
    end
    chk_cnt++;
    if (got.size() != 2 || got[0] !== 36'hA || got[1] !== 36'hB || wr_cnt != 2)
      $display("FAIL mixed_order got n=%0d wr=%0d want A,B wr=2", got.size(), wr_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [DW+2:0] o;
    logic seen = 1'b0;
    drive_cycle(1, 0, 10'd0, '0, 0, obs, exv);
    drive_cycle(1, 0, 10'd1, '0, 0, obs, exv);
    drive_cycle(0, 0, '0, '0, 0, obs, exv);
    drive_cycle(1, 0, 10'd2, '0, 0, obs, exv);
    chk_cnt++;
    if (obs !== exv) $display("FAIL mid_pre got=%h want=%h", obs, exv); else pass_cnt++;
    rst = 1'b1;
    #1;
    o = {rsp_valid, idle, req_ready, rsp_data};
    chk_cnt++;
    if (o !== {1'b0, 1'b1, 1'b0, {DW{1'b0}}}) $display("FAIL mid_reset got=%h want=%h", o, {3'b010, {DW{1'b0}}});
    else pass_cnt++;
    expq.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 0, '0, '0, 1, obs, exv);
      chk_cnt++;
      if (obs !== exv) $display("FAIL mid_quiet k=%0d got=%h want=%h", k, obs, exv); else pass_cnt++;
    end
    drive_cycle(1, 0, 10'd7, '0, 1, obs, exv);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 0, '0, '0, 1, obs, exv);
      chk_cnt++;
      if (obs !== exv) $display("FAIL mid_new k=%0d got=%h want=%h", k, obs, exv); else pass_cnt++;
      if (obs[DW+3] && obs[DW-1:0] === 36'h107) seen = 1'b1;
    end
    chk_cnt++;
    if (!seen) $display("FAIL mid_new_read got=no 0x107 response want=0x107"); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [63:0] r64;
    int errs = 0;
    for (int a = 0; a < 16; a++) begin
      r64 = {$urandom(), $urandom()};
      drive_cycle(1, 1, AW'(a), r64[DW-1:0], 1, obs, exv);
    end
    for (int k = 0; k < 400; k++) begin
      r64 = {$urandom(), $urandom()};
      if (k < 392)
        drive_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                    AW'($urandom_range(0, 15)), r64[DW-1:0], ($urandom_range(0, 2) != 0), obs, exv);
      else
        drive_cycle(0, 0, '0, '0, 1, obs, exv);
      chk_cnt++;
      if (obs !== exv) begin
        errs++;
        if (errs < 10) $display("FAIL random_cycle k=%0d got=%h want=%h", k, obs, exv);
      end else pass_cnt++;
    end
  endtask

  task automatic test_depth1();
    logic [63:0] r64;
    logic [DW+2:0] o, e;
    int a, k;
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r64 = {$urandom(), $urandom()};
      m1[i] = r64[DW-1:0];
      drive1(1, 1, AW'(i), m1[i], 0);
      chk_cnt++;
      if ({req_ready1, ram_wr_en1} !== 2'b11) $display("FAIL d1_write i=%0d got=%b want=11", i, {req_ready1, ram_wr_en1});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 7);
      k = $urandom_range(0, 3);
      drive1(1, 0, AW'(a), '0, 0);
      o = {req_ready1, ram_en1, rsp_valid1, rsp_valid1 ? rsp_data1 : {DW{1'b0}}};
      e = {1'b1, 1'b1, 1'b0, {DW{1'b0}}};
      chk_cnt++;
      if (o !== e) $display("FAIL d1_accept i=%0d got=%h want=%h", i, o, e); else pass_cnt++;
      @(posedge clk); #1;
      drive1(1, 0, AW'((a + 1) % 8), '0, 0);
      o = {req_ready1, ram_en1, rsp_valid1, rsp_valid1 ? rsp_data1 : {DW{1'b0}}};
      e = {1'b0, 1'b0, 1'b0, {DW{1'b0}}};
      chk_cnt++;
      if (o !== e) $display("FAIL d1_inflight i=%0d got=%h want=%h", i, o, e); else pass_cnt++;
      @(posedge clk); #1;
      for (int j = 0; j <= k; j++) begin
        drive1((j != k), 0, AW'((a + 2) % 8), '0, (j == k));
        o = {req_ready1, ram_en1, rsp_valid1, rsp_valid1 ? rsp_data1 : {DW{1'b0}}};
        e = {1'b0, 1'b0, 1'b1, m1[a]};
        chk_cnt++;
        if (o !== e) $display("FAIL d1_resp i=%0d j=%0d got=%h want=%h", i, j, o, e); else pass_cnt++;
        @(posedge clk); #1;
      end
    end
    drive1(0, 0, '0, '0, 1);
    chk_cnt++;
    if ({req_ready1, idle1, rsp_valid1} !== 3'b110)
      $display("FAIL d1_final got=%b want=110", {req_ready1, idle1, rsp_valid1});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stream();
    test_backpressure();
    test_mixed();
    test_reset_mid();
    test_random();
    test_depth1();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/nx_ram_port_ctrl.md
Name: nx_ram_port_ctrl

Overview:
Initiator-side controller for one port of the team's dual-port block RAM (`nx_ram`). Accepts read/write requests on a valid/ready channel and drives the RAM port signals. Captures the RAM's single-cycle registered read data and returns it in order on a valid/ready response channel. Includes a credit-limited response FIFO, so response backpressure never drops read data and the request side sustains one request per cycle.

Parameters:
ADDRESS_WIDTH, 10, RAM word address width; must match the attached RAM port.
DATA_WIDTH, 36, data width of requests, RAM and responses.
RSP_DEPTH, 3, response FIFO entries; must be at least 1; 3 or more gives full read throughput.

Ports:
clk_i  input  1  single clock; RAM port clock must be the same net
rst_i  input  1  asynchronous, active-high reset
req_addr_i  input  ADDRESS_WIDTH  request word address
req_wr_data_i  input  DATA_WIDTH  write data; ignored for reads
req_wr_en_i  input  1  1 = write, 0 = read
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid and ready are both high
rsp_data_o  output  DATA_WIDTH  read response data (FIFO head)
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid and ready are both high
ram_addr_o  output  ADDRESS_WIDTH  to RAM addr
ram_wr_data_o  output  DATA_WIDTH  to RAM wr_data
ram_wr_en_o  output  1  to RAM wr_en
ram_en_o  output  1  to RAM en
ram_rd_data_i  input  DATA_WIDTH  from RAM rd_data; valid the cycle after a read is enabled
idle_o  output  1  no read in flight and response FIFO empty

Behaviour:
- Reset (async assert, clk_i-synchronous release):
  - FIFO empty, pointers 0, occupancy 0, in-flight flag 0.
  - rsp_valid_o=0, rsp_data_o=0, idle_o=1, req_ready_o=0 while rst_i high.
- RAM drive (combinational):
  - ram_en_o = req_valid_i & req_ready_o.
  - ram_wr_en_o = ram_en_o & req_wr_en_i.
  - ram_addr_o = req_addr_i; ram_wr_data_o = req_wr_data_i.
  - When ram_en_o=0, addr and data still pass through but are don't-care.
- Writes:
  - Accepted whenever req_ready_o=1.
  - Produce no response and consume no credit.
- Credits:
  - used = occupancy + inflight, where inflight is a 1-bit register set when a read is accepted.
  - req_ready_o = ~rst_i & (used < RSP_DEPTH).
  - req_ready_o is driven from registered state only: no combinational path from rsp_ready_i or req_valid_i.
  - Writes are gated by the same req_ready_o, which keeps ordering simple.
- Read timing:
  - Cycle N: read accepted.
  - Cycle N+1: inflight=1; ram_rd_data_i is sampled into the FIFO tail at the end of N+1.
  - Cycle N+2: entry visible; rsp_valid_o=1 if the FIFO was empty. Read latency is 2 cycles to rsp_valid_o.
- Throughput: back-to-back reads at one per cycle are sustained with rsp_ready_i held high and RSP_DEPTH>=3.
- Ordering: responses are returned strictly in request order. A write followed by a read to the same address in the next cycle returns the new data; the RAM sequences them.
- FIFO:
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pointers wrap modulo RSP_DEPTH, including non-power-of-two depths.
  - Occupancy width is $clog2(RSP_DEPTH+1).
  - Overflow is impossible by construction; assert this in simulation.
- Response channel:
  - rsp_data_o and rsp_valid_o are stable while rsp_valid_o=1 and rsp_ready_i=0.
  - A pop with rsp_valid_o=0 is ignored.
- idle_o = ~inflight & (occupancy==0), registered-state based.
- Reset mid-operation: in-flight read data and all FIFO contents are discarded; no response is emitted after reset release.

Test Plan:
- Write then read: write 0x123456789 to address 5, then read address 5 with rsp_ready_i=1 → rsp_valid_o high exactly 2 cycles after the read handshake; rsp_data_o=0x123456789; no response for the write.
- Streaming: 8 consecutive reads of addresses 0..7 (preloaded with value = 0x100 + address), rsp_ready_i=1 → req_ready_o never drops; 8 responses 0x100..0x107 in order on consecutive cycles.
- Backpressure: rsp_ready_i=0, issue reads continuously → exactly 3 accepted, then req_ready_o=0 and rsp_data_o held. Raise rsp_ready_i → 3 responses drain in order, req_ready_o returns to 1 one cycle after the first pop.
- Mixed traffic: W(2,0xA), R(2), W(2,0xB), R(2) back-to-back → responses 0xA then 0xB; ram_wr_en_o asserted only on write handshakes.
- Reset mid-stream: assert rst_i the cycle after a read handshake with 2 entries queued → rsp_valid_o=0 and idle_o=1 immediately; no spurious response after release; a new read works normally.
- Depth edge: RSP_DEPTH=1 → only one read outstanding; req_ready_o low from the cycle after acceptance until the response is popped; FIFO pointer wrap checked over 20 reads.
